// File: rtl/mcu_strip_scheduler.sv
// MCU strip scheduler: sequences 4:2:0 MCU readout of a double-banked
// 16-line strip buffer (Y bank plus shared U/V bank), tracks write/read
// bank ownership and generates clamped luma/chroma read addresses.
module mcu_strip_scheduler #(
   parameter int SENSOR_X_SIZE = 720,
   parameter int SENSOR_Y_SIZE = 720
) (
   input  logic                                          clk,
   input  logic                                          resetn,
   input  logic                                          start,
   input  logic [$clog2(SENSOR_X_SIZE)-1:0]              x_size_m1,
   input  logic [$clog2(SENSOR_Y_SIZE)-1:0]              y_size_m1,
   input  logic                                          strip_done,
   output logic                                          wr_bank,
   output logic                                          wr_ready,
   input  logic                                          rd_hold,
   output logic                                          re_luma,
   output logic [$clog2(2*SENSOR_X_SIZE*16/8)-1:0]       ra_luma,
   output logic                                          re_chroma,
   output logic [$clog2(2*SENSOR_X_SIZE*8/8)-1:0]        ra_chroma,
   output logic                                          rd_valid,
   output logic [2:0]                                    mcu_id,
   output logic [2:0]                                    mcu_line,
   output logic                                          gray_out,
   output logic                                          frame_done,
   output logic                                          busy,
   output logic                                          err_overflow
);

   localparam int XW = $clog2(SENSOR_X_SIZE);
   localparam int YW = $clog2(SENSOR_Y_SIZE);
   localparam int BW = XW - 4;
   localparam int SW = YW - 4;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [XW-1:0]   x_lat;
   logic [YW-1:0]   y_lat;
   logic [1:0]      full;
   logic [1:0]      full_nxt;
   logic            rd_bank;
   logic [2:0]      line;
   logic [2:0]      mcu;
   logic [BW-1:0]   blk;
   logic [SW-1:0]   strip;

   logic            step;
   logic            luma_sel;
   logic            line_last;
   logic            mcu_last;
   logic            blk_last;
   logic            strip_last;
   logic            strip_end;
   logic            frame_end;
   logic            wr_accept;
   logic [YW-1:0]   yl;
   logic [YW-1:0]   yc;
   logic [3:0]      row;
   logic [2:0]      crow;
   logic [XW-1:0]   xg;
   logic [YW-1:0]   yg;
   logic            gray;

   // Read-step decode, bank bookkeeping and clamped address generation
   always_comb begin
      busy       = (state == RUN);
      wr_ready   = (state == RUN) & ~full[wr_bank];
      wr_accept  = strip_done & wr_ready;
      step       = (state == RUN) & full[rd_bank] & ~rd_hold;
      luma_sel   = (mcu < 3'd4);
      re_luma    = step & luma_sel;
      re_chroma  = step & ~luma_sel;

      line_last  = (line == 3'd7);
      mcu_last   = (mcu == 3'd5);
      blk_last   = (blk == x_lat[XW-1:4]);
      strip_last = (strip == y_lat[YW-1:4]);
      strip_end  = step & line_last & mcu_last & blk_last;
      frame_end  = strip_end & strip_last;

      // set after clear so a same-bank collision leaves the bank full
      full_nxt = full;
      if (strip_end)
         full_nxt[rd_bank] = 1'b0;
      if (wr_accept)
         full_nxt[wr_bank] = 1'b1;

      // rows below the image bottom replicate the last valid row
      yl        = {strip, mcu[1], line};
      row       = (yl > y_lat) ? y_lat[3:0] : {mcu[1], line};
      ra_luma   = {blk, mcu[0], row, rd_bank};

      yc        = {1'b0, strip, line};
      crow      = (yc > (y_lat >> 1)) ? y_lat[3:1] : line;
      ra_chroma = {blk, crow, rd_bank, mcu[0]};

      xg   = {3'b000, blk, mcu[0]};
      yg   = {3'b000, strip, mcu[1]};
      gray = luma_sel & ((xg > (x_lat >> 3)) | (yg > (y_lat >> 3)));
   end

   // Frame FSM, write/read bank pointers, MCU counters and registered outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         x_lat        <= '0;
         y_lat        <= '0;
         full         <= '0;
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
         line         <= '0;
         mcu          <= '0;
         blk          <= '0;
         strip        <= '0;
         rd_valid     <= 1'b0;
         mcu_id       <= '0;
         mcu_line     <= '0;
         gray_out     <= 1'b0;
         frame_done   <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (start) begin
            state        <= RUN;
            x_lat        <= x_size_m1;
            y_lat        <= y_size_m1;
            full         <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            line         <= '0;
            mcu          <= '0;
            blk          <= '0;
            strip        <= '0;
            rd_valid     <= 1'b0;
            err_overflow <= 1'b0;
         end else begin
            full <= full_nxt;
            if (strip_done & ~wr_ready)
               err_overflow <= 1'b1;
            if (wr_accept)
               wr_bank <= ~wr_bank;
            if (!rd_hold)
               rd_valid <= step;
            if (step) begin
               mcu_id   <= mcu;
               mcu_line <= line;
               gray_out <= gray;
               if (!line_last) begin
                  line <= line + 3'd1;
               end else begin
                  line <= '0;
                  if (!mcu_last) begin
                     mcu <= mcu + 3'd1;
                  end else begin
                     mcu <= '0;
                     if (!blk_last) begin
                        blk <= blk + BW'(1);
                     end else begin
                        blk <= '0;
                        if (!strip_last)
                           strip <= strip + SW'(1);
                        else
                           strip <= '0;
                     end
                  end
               end
               if (strip_end)
                  rd_bank <= ~rd_bank;
               if (frame_end) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mcu_strip_scheduler.sv
// Testbench for mcu_strip_scheduler: randomized holds and strip arrivals
// checked against a frame-level reference model (strip occupancy count and
// a linear read index decomposed into strip/block/MCU/line).
module tb_mcu_strip_scheduler;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [9:0]  x_size_m1;
   logic [9:0]  y_size_m1;
   logic        strip_done;
   logic        wr_bank;
   logic        wr_ready;
   logic        rd_hold;
   logic        re_luma;
   logic [11:0] ra_luma;
   logic        re_chroma;
   logic [10:0] ra_chroma;
   logic        rd_valid;
   logic [2:0]  mcu_id;
   logic [2:0]  mcu_line;
   logic        gray_out;
   logic        frame_done;
   logic        busy;
   logic        err_overflow;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int m_run, m_x, m_y, m_avail, m_k, m_wrb, m_err;
   int m_valid, m_id, m_line, m_gray, m_fd;

   mcu_strip_scheduler #(.SENSOR_X_SIZE(720), .SENSOR_Y_SIZE(720)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .x_size_m1    (x_size_m1),
      .y_size_m1    (y_size_m1),
      .strip_done   (strip_done),
      .wr_bank      (wr_bank),
      .wr_ready     (wr_ready),
      .rd_hold      (rd_hold),
      .re_luma      (re_luma),
      .ra_luma      (ra_luma),
      .re_chroma    (re_chroma),
      .ra_chroma    (ra_chroma),
      .rd_valid     (rd_valid),
      .mcu_id       (mcu_id),
      .mcu_line     (mcu_line),
      .gray_out     (gray_out),
      .frame_done   (frame_done),
      .busy         (busy),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_x = 0; m_y = 0; m_avail = 0; m_k = 0; m_wrb = 0; m_err = 0;
      m_valid = 0; m_id = 0; m_line = 0; m_gray = 0; m_fd = 0;
   endtask

   // one clock: drive inputs, check combinational outputs before the edge,
   // advance the model, then check registered outputs after the edge
   task automatic cycle(input logic st, input logic sd, input logic hold);
      int per, s, r, b, m, l, mh, yr, row, crow, la, ca, g, step_e, acc, send;
      start = st; strip_done = sd; rd_hold = hold;
      @(negedge clk);
      step_e = (m_run != 0 && m_avail > 0 && !hold) ? 1 : 0;
      per  = (m_x / 16 + 1) * 48;
      s    = m_k / per;
      r    = m_k % per;
      b    = r / 48;
      m    = (r % 48) / 8;
      l    = r % 8;
      mh   = m / 2;
      yr   = s * 16 + mh * 8 + l;
      row  = (yr > m_y) ? (m_y % 16) : (mh * 8 + l);
      la   = ((b * 2 + m % 2) * 16 + row) * 2 + s % 2;
      crow = ((s * 8 + l) > (m_y / 2)) ? ((m_y % 16) / 2) : l;
      ca   = ((b * 8 + crow) * 2 + s % 2) * 2 + m % 2;
      g    = (m < 4 && ((b * 2 + m % 2) > (m_x / 8) || (s * 2 + mh) > (m_y / 8))) ? 1 : 0;
      check_value("wr_ready", wr_ready, (m_run != 0 && m_avail < 2) ? 1 : 0);
      check_value("re_luma", re_luma, (step_e != 0 && m < 4) ? 1 : 0);
      check_value("re_chroma", re_chroma, (step_e != 0 && m >= 4) ? 1 : 0);
      if (step_e != 0 && m < 4)  check_value("ra_luma", ra_luma, la);
      if (step_e != 0 && m >= 4) check_value("ra_chroma", ra_chroma, ca);
      @(posedge clk);
      #1;
      if (!resetn) begin
         model_reset();
      end else if (st) begin
         m_run = 1; m_x = x_size_m1; m_y = y_size_m1; m_avail = 0; m_k = 0;
         m_wrb = 0; m_err = 0; m_valid = 0; m_fd = 0;
      end else begin
         acc  = (sd && m_run != 0 && m_avail < 2) ? 1 : 0;
         send = 0;
         m_fd = 0;
         if (sd && acc == 0) m_err = 1;
         if (step_e != 0) begin
            m_id = m; m_line = l; m_gray = g;
            m_k++;
            if (m_k % per == 0) send = 1;
            if (m_k == per * (m_y / 16 + 1)) begin
               m_run = 0; m_fd = 1; m_k = 0;
            end
         end
         if (!hold) m_valid = step_e;
         m_avail = m_avail - send + acc;
         if (acc != 0) m_wrb = m_wrb ^ 1;
      end
      check_value("rd_valid", rd_valid, m_valid);
      check_value("mcu_id", mcu_id, m_id);
      check_value("mcu_line", mcu_line, m_line);
      check_value("gray_out", gray_out, m_gray);
      check_value("frame_done", frame_done, m_fd);
      check_value("err_overflow", err_overflow, m_err);
      check_value("wr_bank", wr_bank, m_wrb);
      check_value("busy", busy, m_run);
   endtask

   task automatic begin_frame(input int x, input int y);
      x_size_m1 = 10'(x);
      y_size_m1 = 10'(y);
      cycle(1'b1, 1'b0, 1'b0);
   endtask

   task automatic run_frame(input int hold_pct, input int sd_pct, input int budget);
      for (int i = 0; i < budget && m_run != 0; i++)
         cycle(1'b0, ($urandom_range(0, 99) < sd_pct), ($urandom_range(0, 99) < hold_pct));
      check_value("frame_end", busy, 0);
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; strip_done = 1'b0; rd_hold = 1'b0;
      x_size_m1 = '0; y_size_m1 = '0;
      model_reset();
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      resetn = 1'b1;
      check_value("ra_luma_rst", ra_luma, 0);
      check_value("ra_chroma_rst", ra_chroma, 0);

      // single aligned 16x16 strip, no stalls
      begin_frame(15, 15);
      cycle(1'b0, 1'b1, 1'b0);
      run_frame(0, 0, 200);
      cycle(1'b0, 1'b0, 1'b0);

      // two blocks, right block partly grayed, random stalls
      begin_frame(23, 15);
      cycle(1'b0, 1'b1, 1'b0);
      run_frame(25, 0, 800);

      // 20-line image: second strip clamped and grayed
      begin_frame(15, 19);
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      run_frame(20, 0, 800);

      // 5-cycle hold in the middle of an MCU
      begin_frame(15, 15);
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b0, 1'b1);
      run_frame(0, 0, 200);

      // overflow: third strip with both banks full, cleared by next start
      begin_frame(15, 15);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      begin_frame(15, 15);
      cycle(1'b0, 1'b1, 1'b0);
      run_frame(0, 0, 200);

      // restart in the middle of a frame
      begin_frame(31, 31);
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
      begin_frame(15, 15);
      cycle(1'b0, 1'b1, 1'b0);
      run_frame(10, 0, 400);

      // random sizes, random strip arrivals and stalls
      for (int f = 0; f < 6; f++) begin
         begin_frame($urandom_range(0, 63), $urandom_range(0, 47));
         run_frame(20, 10, 6000);
         cycle(1'b0, 1'b0, 1'b0);
      end

      // reset for one cycle mid-strip, then strip_done while idle
      begin_frame(31, 15);
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b0);
      resetn = 1'b0;
      cycle(1'b0, 1'b0, 1'b0);
      resetn = 1'b1;
      check_value("ra_luma_rst2", ra_luma, 0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
      begin_frame(15, 15);
      cycle(1'b0, 1'b1, 1'b0);
      run_frame(0, 0, 200);
      cycle(1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
